// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single fixed-latency unified memory.
// Optional performance counters are built when MEM_ARBITER_PERF_EN is defined.
module mem_arbiter #(
  parameter int AWIDTH          = 32,
  parameter int DWIDTH          = 32,
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic [2:0]        d_funct3_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic              busy_o,
  output logic [31:0]       perf_if_cnt_o,
  output logic [31:0]       perf_d_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [2:0] LAT_INIT   = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  logic [0:0]        state;
  logic [3:0]        streak;
  logic [2:0]        lat_cnt;
  logic [AWIDTH-1:0] cmd_addr;
  logic [DWIDTH-1:0] cmd_data;
  logic              cmd_we;
  logic [2:0]        cmd_funct3;
  logic              cmd_src_d;
  logic [DWIDTH-1:0] if_rdata_q;
  logic [DWIDTH-1:0] d_rdata_q;
  logic              if_rvalid_q;
  logic              d_rvalid_q;
  logic              in_idle;
  logic              fetch_wins;

  assign in_idle    = (state == IDLE);
  // Data has priority until it has starved a waiting fetch for STREAK_MAX grants.
  assign fetch_wins = if_req_i && ((streak == STREAK_MAX) || !d_req_i);
  assign if_gnt_o   = in_idle && fetch_wins;
  assign d_gnt_o    = in_idle && d_req_i && !fetch_wins;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      streak      <= '0;
      lat_cnt     <= '0;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      cmd_we      <= 1'b0;
      cmd_funct3  <= '0;
      cmd_src_d   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if (state == IDLE) begin
        if (if_gnt_o) begin
          cmd_addr   <= if_addr_i;
          cmd_data   <= '0;
          cmd_we     <= 1'b0;
          cmd_funct3 <= FUNCT3_WORD;
          cmd_src_d  <= 1'b0;
          streak     <= '0;
          lat_cnt    <= LAT_INIT;
          state      <= WAIT;
        end else if (d_gnt_o) begin
          cmd_addr   <= d_addr_i;
          cmd_data   <= d_wdata_i;
          cmd_we     <= d_we_i;
          cmd_funct3 <= d_funct3_i;
          cmd_src_d  <= 1'b1;
          if (!if_req_i) streak <= '0;
          else if (streak != STREAK_MAX) streak <= streak + 4'd1;
          lat_cnt    <= LAT_INIT;
          state      <= WAIT;
        end
      end else begin
        if (lat_cnt == 3'd0) begin
          state <= IDLE;
          if (cmd_src_d) begin
            d_rvalid_q <= 1'b1;
            if (!cmd_we) d_rdata_q <= mem_data_i;
          end else begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= mem_data_i;
          end
        end else begin
          lat_cnt <= lat_cnt - 3'd1;
        end
      end
    end
  end

  assign busy_o         = !in_idle;
  assign mem_addr_o     = in_idle ? '0 : cmd_addr;
  assign mem_data_o     = in_idle ? '0 : cmd_data;
  assign mem_funct3_o   = in_idle ? FUNCT3_WORD : cmd_funct3;
  assign mem_read_en_o  = !in_idle && !cmd_we;
  // Stores are single-shot: the first WAIT cycle is the one still holding LAT_INIT.
  assign mem_write_en_o = !in_idle && cmd_we && (lat_cnt == LAT_INIT);
  assign if_rvalid_o    = if_rvalid_q;
  assign d_rvalid_o     = d_rvalid_q;
  assign if_rdata_o     = if_rdata_q;
  assign d_rdata_o      = d_rdata_q;

`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] perf_if_q;
  logic [31:0] perf_d_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_q    <= '0;
      perf_d_q     <= '0;
      perf_stall_q <= '0;
    end else begin
      if (if_gnt_o) perf_if_q <= perf_if_q + 32'd1;
      if (d_gnt_o) perf_d_q <= perf_d_q + 32'd1;
      if ((if_req_i || d_req_i) && !if_gnt_o && !d_gnt_o) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_if_cnt_o    = perf_if_q;
  assign perf_d_cnt_o     = perf_d_q;
  assign perf_stall_cnt_o = perf_stall_q;
`else
  assign perf_if_cnt_o    = '0;
  assign perf_d_cnt_o     = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3,
// sharing the requester and memory-side inputs.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_funct3;
  logic [31:0] mem_rdata;

  logic        if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, rd_en_1, wr_en_1, busy_1;
  logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_data_1, perf_if_1, perf_d_1, perf_st_1;
  logic [2:0]  funct3_1;
  logic        if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, rd_en_3, wr_en_3, busy_3;
  logic [31:0] if_rdata_3, d_rdata_3, mem_addr_3, mem_data_3, perf_if_3, perf_d_3, perf_st_3;
  logic [2:0]  funct3_3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_1),
    .if_rvalid_o(if_rvalid_1), .if_rdata_o(if_rdata_1),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_funct3_i(d_funct3), .d_gnt_o(d_gnt_1), .d_rvalid_o(d_rvalid_1), .d_rdata_o(d_rdata_1),
    .mem_addr_o(mem_addr_1), .mem_data_o(mem_data_1), .mem_read_en_o(rd_en_1),
    .mem_write_en_o(wr_en_1), .mem_funct3_o(funct3_1), .mem_data_i(mem_rdata),
    .busy_o(busy_1), .perf_if_cnt_o(perf_if_1), .perf_d_cnt_o(perf_d_1),
    .perf_stall_cnt_o(perf_st_1)
  );

  mem_arbiter #(.MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_3),
    .if_rvalid_o(if_rvalid_3), .if_rdata_o(if_rdata_3),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_funct3_i(d_funct3), .d_gnt_o(d_gnt_3), .d_rvalid_o(d_rvalid_3), .d_rdata_o(d_rdata_3),
    .mem_addr_o(mem_addr_3), .mem_data_o(mem_data_3), .mem_read_en_o(rd_en_3),
    .mem_write_en_o(wr_en_3), .mem_funct3_o(funct3_3), .mem_data_i(mem_rdata),
    .busy_o(busy_3), .perf_if_cnt_o(perf_if_3), .perf_d_cnt_o(perf_d_3),
    .perf_stall_cnt_o(perf_st_3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int        n_rec;
    logic [5:0] order;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_funct3 = 3'b010; mem_rdata = '0;
    ticks(3);
    chk("rst_busy", {31'd0, busy_1}, 32'd0);
    chk("rst_gnt", {30'd0, if_gnt_1, d_gnt_1}, 32'd0);
    chk("rst_funct3", {29'd0, funct3_1}, 32'd2);
    chk("rst_mem_addr", mem_addr_1, 32'd0);
    chk("rst_rdata", if_rdata_1 | d_rdata_1, 32'd0);
    chk("rst_perf", perf_if_1 | perf_d_1 | perf_st_1, 32'd0);
    rst = 1'b0;
    tick();

    // single fetch on the latency-1 instance
    if_req = 1'b1; if_addr = 32'h0100_0000; mem_rdata = 32'h0000_0013;
    #1;
    chk("f1_if_gnt", {31'd0, if_gnt_1}, 32'd1);
    chk("f1_d_gnt", {31'd0, d_gnt_1}, 32'd0);
    tick(); if_req = 1'b0;
    chk("f1_rd_en", {31'd0, rd_en_1}, 32'd1);
    chk("f1_addr", mem_addr_1, 32'h0100_0000);
    chk("f1_busy_gnt", {30'd0, busy_1, if_gnt_1}, 32'd2);
    tick();
    chk("f1_rvalid", {31'd0, if_rvalid_1}, 32'd1);
    chk("f1_rdata", if_rdata_1, 32'h0000_0013);
    chk("f1_rd_en_idle", {31'd0, rd_en_1}, 32'd0);
    tick();
    chk("f1_rvalid_pulse", {31'd0, if_rvalid_1}, 32'd0);
    ticks(4);

    // simultaneous fetch and load: data first, fetch MEM_LATENCY+1 later
    if_req = 1'b1; if_addr = 32'h0100_0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0100; d_funct3 = 3'b010;
    mem_rdata = 32'h1111_2222;
    #1;
    chk("sim_d_first", {30'd0, if_gnt_1, d_gnt_1}, 32'd1);
    tick(); d_req = 1'b0;
    chk("sim_addr", mem_addr_1, 32'h0100_0100);
    tick();
    chk("sim_d_rvalid", {31'd0, d_rvalid_1}, 32'd1);
    chk("sim_d_rdata", d_rdata_1, 32'h1111_2222);
    chk("sim_if_gnt", {31'd0, if_gnt_1}, 32'd1);
    tick(); if_req = 1'b0;
    ticks(8);

    // both held high: grant order on latency-1 instance
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0104;
    n_rec = 0; order = '0;
    #1;
    for (int c = 0; c < 30 && n_rec < 6; c++) begin
      if (if_gnt_1 && d_gnt_1) chk("order_both_gnt", 32'd1, 32'd0);
      if (if_gnt_1 || d_gnt_1) begin
        order[n_rec] = if_gnt_1;
        n_rec++;
      end
      if (n_rec < 6) tick();
    end
    chk("order_count", n_rec, 32'd6);
    chk("order_DDDDFD", {26'd0, order}, 32'b010000);
    tick(); if_req = 1'b0; d_req = 1'b0;
    ticks(8);

    // load to seed d_rdata, then a store on the latency-3 instance
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0300; mem_rdata = 32'hCAFE_F00D;
    tick(); d_req = 1'b0;
    ticks(6);
    chk("ld3_rdata", d_rdata_3, 32'hCAFE_F00D);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0200; d_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h5555_5555;
    #1;
    chk("st_gnt", {31'd0, d_gnt_3}, 32'd1);
    tick(); d_req = 1'b0;
    chk("st_we_c1", {30'd0, wr_en_3, rd_en_3}, 32'd2);
    chk("st_data", mem_data_3, 32'hDEAD_BEEF);
    chk("st_addr", mem_addr_3, 32'h0100_0200);
    tick();
    chk("st_we_c2", {30'd0, wr_en_3, busy_3}, 32'd1);
    tick();
    chk("st_we_c3", {30'd0, wr_en_3, d_rvalid_3}, 32'd0);
    tick();
    chk("st_rvalid_c4", {30'd0, d_rvalid_3, busy_3}, 32'd2);
    chk("st_rdata_kept", d_rdata_3, 32'hCAFE_F00D);
    ticks(4);

    // reset in second WAIT cycle of a latency-3 load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0400; mem_rdata = 32'h7777_7777;
    tick(); d_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("ab_busy_rd", {30'd0, busy_3, rd_en_3}, 32'd0);
    chk("ab_addr", mem_addr_3, 32'd0);
    chk("ab_funct3", {29'd0, funct3_3}, 32'd2);
    chk("ab_rdata", d_rdata_3, 32'd0);
    tick(); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("ab_no_rvalid", {30'd0, d_rvalid_3, if_rvalid_3}, 32'd0);
      tick();
    end
    if_req = 1'b1; if_addr = 32'h0100_0008;
    #1;
    chk("ab_regrant", {31'd0, if_gnt_3}, 32'd1);
    tick(); if_req = 1'b0;
    ticks(3);
    chk("ab_if_rvalid", {31'd0, if_rvalid_3}, 32'd1);
    chk("ab_if_rdata", if_rdata_3, 32'h7777_7777);
    ticks(4);

`ifdef MEM_ARBITER_PERF_EN
    rst = 1'b1; tick(); rst = 1'b0; tick();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; #1;
    chk("pf_d_gnt", {31'd0, d_gnt_1}, 32'd1);
    tick(); d_req = 1'b0;
    tick();
    chk("pf_if_gnt", {31'd0, if_gnt_1}, 32'd1);
    tick(); if_req = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      if_req = (k < 2); d_req = (k == 2); #1;
      chk("pf_single_gnt", {31'd0, if_gnt_1 | d_gnt_1}, 32'd1);
      tick(); if_req = 1'b0; d_req = 1'b0;
      tick();
    end
    chk("pf_if_cnt", perf_if_1, 32'd3);
    chk("pf_d_cnt", perf_d_1, 32'd2);
    chk("pf_stall_cnt", perf_st_1, 32'd1);
`else
    chk("perf_tied_off", perf_if_1 | perf_d_1 | perf_st_1 | perf_if_3 | perf_d_3 | perf_st_3,
        32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
